// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO peripheral block: register offsets within the
// 0xFFFFxxxx window, control-bit positions and small byte-lane helpers.
package mmio_pkg;

  localparam logic [15:0] OFF_UART_TX   = 16'h0000;
  localparam logic [15:0] OFF_UART_STAT = 16'h0004;
  localparam logic [15:0] OFF_DISP      = 16'h0010;
  localparam logic [15:0] OFF_SWITCH    = 16'h0014;
  localparam logic [15:0] OFF_LED       = 16'h0020;
  localparam logic [15:0] OFF_T1_LOAD   = 16'h0030;
  localparam logic [15:0] OFF_T1_CTRL   = 16'h0034;
  localparam logic [15:0] OFF_T2_LOAD   = 16'h0038;
  localparam logic [15:0] OFF_T2_CTRL   = 16'h003C;
  localparam logic [15:0] OFF_PWM_PER   = 16'h0040;
  localparam logic [15:0] OFF_PWM_DUTY  = 16'h0044;
  localparam logic [15:0] OFF_PWM_CTRL  = 16'h0048;
  localparam logic [15:0] OFF_WDT_KICK  = 16'h0050;
  localparam logic [15:0] OFF_WDT_CTRL  = 16'h0054;
  localparam logic [15:0] OFF_KEY_CODE  = 16'hFC10;
  localparam logic [15:0] OFF_KEY_STAT  = 16'hFC14;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_CLR  = 2;
  localparam int CTRL_PEND = 31;

  function automatic logic [31:0] be_merge32(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be_v);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be_v[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [15:0] be_merge16(input logic [15:0] old_v,
                                             input logic [15:0] new_v,
                                             input logic [1:0]  be_v);
    logic [15:0] r;
    r = old_v;
    if (be_v[0]) r[7:0]  = new_v[7:0];
    if (be_v[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  // Keypad column lines are active low; the lowest pressed column wins.
  function automatic logic [1:0] low_zero_idx(input logic [3:0] c);
    logic [1:0] r;
    if (!c[0])      r = 2'd0;
    else if (!c[1]) r = 2'd1;
    else if (!c[2]) r = 2'd2;
    else            r = 2'd3;
    return r;
  endfunction

endpackage

// File: rtl/mmio_keypad_scan.sv
// 4x4 matrix keypad scanner: rotates one active-low row, samples the columns on
// the last cycle of each row dwell and latches the key code with a valid flag.
module mmio_keypad_scan
  import mmio_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  input  logic       clr,
  output logic [3:0] row,
  output logic [3:0] code,
  output logic       valid
);

  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          last_dwell, key_hit;

  always_comb begin
    last_dwell = (div_q == '0);
    key_hit    = last_dwell && (col != 4'hF);
    div_d      = last_dwell ? DIV_RELOAD : div_q - DW'(1);
    idx_d      = last_dwell ? idx_q + 2'd1 : idx_q;
    code_d     = key_hit ? {idx_q, low_zero_idx(col)} : code_q;
    // A fresh detection outranks a software clear in the same cycle.
    valid_d    = key_hit | (valid_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DIV_RELOAD;
      idx_q   <= 2'd0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign row   = ~(4'b0001 << idx_q);
  assign code  = code_q;
  assign valid = valid_q;

endmodule

// File: rtl/mmio_if.sv
// Memory-mapped peripheral block at 0xFFFFxxxx: UART port, display, switches,
// LEDs, two timers, PWM, watchdog and keypad. Writes registered, reads combinational.
module mmio_if
  import mmio_pkg::*;
#(
  parameter int          SCAN_DIV    = 50000,
  parameter logic [31:0] WDT_DEFAULT = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx_ready,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  output logic [31:0] disp_data,
  input  logic [31:0] switch_data,
  output logic [15:0] led_out,
  output logic        pwm_out,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        sys_rst_req,
  output logic [1:0]  timer_int
);

  logic        hit, wr;
  logic [15:0] off;
  assign hit = (addr[31:16] == 16'hFFFF);
  assign off = addr[15:0];
  assign wr  = we && hit;

  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic [31:0] disp_q, disp_d;
  logic [15:0] led_q, led_d;

  logic [31:0] tload_q [2];
  logic [31:0] tload_d [2];
  logic [31:0] tcnt_q  [2];
  logic [31:0] tcnt_d  [2];
  logic [1:0]  ten_q, ten_d, tar_q, tar_d, tpend_q, tpend_d, texp;
  logic [1:0]  wr_tload, wr_tctrl;
  assign wr_tload = {wr && off == OFF_T2_LOAD, wr && off == OFF_T1_LOAD};
  assign wr_tctrl = {wr && off == OFF_T2_CTRL && be[0], wr && off == OFF_T1_CTRL && be[0]};

  logic [15:0] pwm_per_q, pwm_per_d, pwm_duty_q, pwm_duty_d, pwm_cnt_q, pwm_cnt_d;
  logic        pwm_en_q, pwm_en_d, pwm_q, pwm_d;

  logic [31:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_en_q, wdt_en_d, req_q, req_d, wdt_kick, wdt_ctrl_wr, wdt_reload;

  logic [3:0]  key_code;
  logic        key_valid, key_clr;

  always_comb begin
    tx_en_d   = wr && off == OFF_UART_TX && be[0];
    tx_data_d = tx_en_d ? wdata[7:0] : tx_data_q;
    disp_d    = (wr && off == OFF_DISP) ? be_merge32(disp_q, wdata, be) : disp_q;
    led_d     = (wr && off == OFF_LED) ? be_merge16(led_q, wdata[15:0], be[1:0]) : led_q;
    texp      = '0;
    for (int n = 0; n < 2; n++) begin
      tload_d[n] = tload_q[n];
      tcnt_d[n]  = tcnt_q[n];
      ten_d[n]   = ten_q[n];
      tar_d[n]   = tar_q[n];
      texp[n]    = ten_q[n] && (tcnt_q[n] == '0);
      if (texp[n]) begin
        if (tar_q[n]) tcnt_d[n] = tload_q[n];
        else          ten_d[n]  = 1'b0;
      end else if (ten_q[n]) begin
        tcnt_d[n] = tcnt_q[n] - 32'd1;
      end
      if (wr_tload[n]) begin
        tload_d[n] = be_merge32(tload_q[n], wdata, be);
        tcnt_d[n]  = be_merge32(tload_q[n], wdata, be);
      end
      if (wr_tctrl[n]) begin
        ten_d[n] = wdata[CTRL_EN];
        tar_d[n] = wdata[CTRL_AR];
      end
      tpend_d[n] = texp[n] | (tpend_q[n] & ~(wr_tctrl[n] & wdata[CTRL_CLR]));
    end
  end

  always_comb begin
    pwm_per_d  = (wr && off == OFF_PWM_PER) ? be_merge16(pwm_per_q, wdata[15:0], be[1:0]) : pwm_per_q;
    pwm_duty_d = (wr && off == OFF_PWM_DUTY) ? be_merge16(pwm_duty_q, wdata[15:0], be[1:0]) : pwm_duty_q;
    pwm_en_d   = (wr && off == OFF_PWM_CTRL && be[0]) ? wdata[CTRL_EN] : pwm_en_q;
    if (!pwm_en_q || pwm_per_q == '0 || pwm_cnt_q >= pwm_per_q - 16'd1) pwm_cnt_d = '0;
    else                                                                 pwm_cnt_d = pwm_cnt_q + 16'd1;
    pwm_d = pwm_en_q && (pwm_per_q != '0) && (pwm_cnt_q < pwm_duty_q);
  end

  always_comb begin
    wdt_kick    = wr && off == OFF_WDT_KICK;
    wdt_ctrl_wr = wr && off == OFF_WDT_CTRL && be[0];
    wdt_reload  = wdt_kick || (wdt_ctrl_wr && wdata[CTRL_EN]);
    wdt_en_d    = wdt_ctrl_wr ? wdata[CTRL_EN] : wdt_en_q;
    if (wdt_reload)                         wdt_cnt_d = WDT_DEFAULT;
    else if (wdt_en_q && wdt_cnt_q != '0)   wdt_cnt_d = wdt_cnt_q - 32'd1;
    else                                    wdt_cnt_d = wdt_cnt_q;
    // The pulse ends on its own: the request feeds back into rst.
    req_d = wdt_en_q && (wdt_cnt_q == '0) && !wdt_reload;
  end

  assign key_clr = wr && off == OFF_KEY_STAT && be[0] && wdata[0];

  mmio_keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_keypad (
    .clk   (clk),
    .rst   (rst),
    .col   (col),
    .clr   (key_clr),
    .row   (row),
    .code  (key_code),
    .valid (key_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= '0;  tx_en_q <= 1'b0;  disp_q <= '0;  led_q <= '0;
      for (int n = 0; n < 2; n++) begin
        tload_q[n] <= '0;
        tcnt_q[n]  <= '0;
      end
      ten_q <= '0;  tar_q <= '0;  tpend_q <= '0;
      pwm_per_q <= '0;  pwm_duty_q <= '0;  pwm_cnt_q <= '0;  pwm_en_q <= 1'b0;  pwm_q <= 1'b0;
      wdt_cnt_q <= '0;  wdt_en_q <= 1'b0;  req_q <= 1'b0;
    end else begin
      tx_data_q <= tx_data_d;  tx_en_q <= tx_en_d;  disp_q <= disp_d;  led_q <= led_d;
      for (int n = 0; n < 2; n++) begin
        tload_q[n] <= tload_d[n];
        tcnt_q[n]  <= tcnt_d[n];
      end
      ten_q <= ten_d;  tar_q <= tar_d;  tpend_q <= tpend_d;
      pwm_per_q <= pwm_per_d;  pwm_duty_q <= pwm_duty_d;  pwm_cnt_q <= pwm_cnt_d;
      pwm_en_q  <= pwm_en_d;   pwm_q <= pwm_d;
      wdt_cnt_q <= wdt_cnt_d;  wdt_en_q <= wdt_en_d;  req_q <= req_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_UART_TX:   rdata = {24'b0, tx_data_q};
        OFF_UART_STAT: rdata = {31'b0, uart_rx_ready};
        OFF_DISP:      rdata = disp_q;
        OFF_SWITCH:    rdata = switch_data;
        OFF_LED:       rdata = {16'b0, led_q};
        OFF_T1_LOAD:   rdata = tload_q[0];
        OFF_T1_CTRL:   rdata = {tpend_q[0], 29'b0, tar_q[0], ten_q[0]};
        OFF_T2_LOAD:   rdata = tload_q[1];
        OFF_T2_CTRL:   rdata = {tpend_q[1], 29'b0, tar_q[1], ten_q[1]};
        OFF_PWM_PER:   rdata = {16'b0, pwm_per_q};
        OFF_PWM_DUTY:  rdata = {16'b0, pwm_duty_q};
        OFF_PWM_CTRL:  rdata = {31'b0, pwm_en_q};
        OFF_WDT_CTRL:  rdata = {31'b0, wdt_en_q};
        OFF_KEY_CODE:  rdata = {28'b0, key_code};
        OFF_KEY_STAT:  rdata = {31'b0, key_valid};
        default:       rdata = '0;
      endcase
    end
  end

  assign uart_tx_en   = tx_en_q;
  assign uart_tx_data = tx_data_q;
  assign disp_data    = disp_q;
  assign led_out      = led_q;
  assign pwm_out      = pwm_q;
  assign sys_rst_req  = req_q;
  assign timer_int    = tpend_q;

endmodule

// File: tb/tb_mmio_if.sv
// Directed bench for mmio_if: register table plus hand-timed sequences for
// timers, PWM, keypad, UART pulse and the watchdog self-reset.
module tb_mmio_if;

  logic        clk = 1'b0;
  logic        ext_rst, rst, we;
  logic [3:0]  be, col, row;
  logic [31:0] addr, wdata, rdata, disp_data, switch_data;
  logic        uart_rx_ready, uart_tx_en, pwm_out, sys_rst_req, key_en;
  logic [7:0]  uart_tx_data;
  logic [15:0] led_out;
  logic [1:0]  timer_int;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rst = ext_rst | sys_rst_req;
  assign col = (key_en && row == 4'b1101) ? 4'b1011 : 4'hF;

  mmio_if #(.SCAN_DIV(4), .WDT_DEFAULT(32'd20)) dut (
    .clk(clk), .rst(rst), .we(we), .be(be), .addr(addr), .wdata(wdata), .rdata(rdata),
    .uart_rx_ready(uart_rx_ready), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .disp_data(disp_data), .switch_data(switch_data), .led_out(led_out), .pwm_out(pwm_out),
    .col(col), .row(row), .sys_rst_req(sys_rst_req), .timer_int(timer_int)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    we = 1'b0; be = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    we = 1'b0; addr = a;
    #1;
    d = rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int bad;
    bit found;

    vecs[0]  = '{1'b0, 4'h0, 32'hFFFF0014, 32'h0,        32'hA5A55A5A};
    vecs[1]  = '{1'b1, 4'h1, 32'hFFFF0020, 32'h1234ABCD, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 32'hFFFF0020, 32'h0,        32'h000000CD};
    vecs[3]  = '{1'b1, 4'hF, 32'hFFFF0010, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b1, 4'h4, 32'hFFFF0010, 32'h00000000, 32'h0};
    vecs[5]  = '{1'b0, 4'h0, 32'hFFFF0010, 32'h0,        32'hDE00BEEF};
    vecs[6]  = '{1'b0, 4'h0, 32'hFFFF0004, 32'h0,        32'h00000001};
    vecs[7]  = '{1'b0, 4'h0, 32'hFFFF0100, 32'h0,        32'h00000000};
    vecs[8]  = '{1'b1, 4'hF, 32'hFFFF0024, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 32'hFFFF0020, 32'h0,        32'h000000CD};
    vecs[10] = '{1'b1, 4'hF, 32'hFFFF0040, 32'h0000000A, 32'h0};
    vecs[11] = '{1'b0, 4'h0, 32'hFFFF0040, 32'h0,        32'h0000000A};
    vecs[12] = '{1'b1, 4'h1, 32'hFFFF0044, 32'h00001234, 32'h0};
    vecs[13] = '{1'b0, 4'h0, 32'hFFFF0044, 32'h0,        32'h00000034};
    vecs[14] = '{1'b0, 4'h0, 32'hFFFFFC10, 32'h0,        32'h00000000};
    vecs[15] = '{1'b0, 4'h0, 32'hFFFFFC14, 32'h0,        32'h00000000};
    vecs[16] = '{1'b0, 4'h0, 32'h00000014, 32'h0,        32'h00000000};
    vecs[17] = '{1'b0, 4'h0, 32'hFFFF0054, 32'h0,        32'h00000000};

    ext_rst = 1'b1; we = 1'b0; be = 4'h0; addr = 32'hFFFF0020; wdata = '0;
    uart_rx_ready = 1'b1; switch_data = 32'hA5A55A5A; key_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ext_rst = 1'b0;
    #1;
    check("rst_rdata_led", rdata, 32'h0);
    check("rst_row", 32'(row), 32'hE);
    check("rst_timer_int", 32'(timer_int), 32'h0);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_sys_req", 32'(sys_rst_req), 32'h0);
    check("rst_tx_en", 32'(uart_tx_en), 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].we) bus_wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else begin
        bus_rd(vecs[i].addr, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end
    check("led_out_port", 32'(led_out), 32'h00CD);
    check("disp_port", disp_data, 32'hDE00BEEF);

    // Timer1 auto-reload: edge E0 = CTRL write
    bus_wr(32'hFFFF0030, 32'd5, 4'hF);
    bus_wr(32'hFFFF0034, 32'd3, 4'hF);
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (timer_int[0]) bad++;
    end
    check("t1_no_early", 32'(bad), 32'd0);
    @(posedge clk); #1;
    check("t1_pend_e6", 32'(timer_int[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_pend_held", 32'(timer_int[0]), 32'd1);
    bus_wr(32'hFFFF0034, 32'd7, 4'hF);
    check("t1_clr", 32'(timer_int[0]), 32'd0);
    @(posedge clk); #1;
    check("t1_clr_e11", 32'(timer_int[0]), 32'd0);
    @(posedge clk); #1;
    check("t1_resume_e12", 32'(timer_int[0]), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    bus_wr(32'hFFFF0034, 32'd7, 4'hF);
    check("t1_set_wins", 32'(timer_int[0]), 32'd1);
    bus_wr(32'hFFFF0034, 32'd4, 4'hF);
    check("t1_off_clr", 32'(timer_int[0]), 32'd0);

    // Timer2 one-shot
    bus_wr(32'hFFFF0038, 32'd2, 4'hF);
    bus_wr(32'hFFFF003C, 32'd1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("t2_before", 32'(timer_int[1]), 32'd0);
    @(posedge clk); #1;
    check("t2_expire", 32'(timer_int[1]), 32'd1);
    bus_rd(32'hFFFF003C, d);
    check("t2_ctrl_rd", d, 32'h80000000);
    bus_wr(32'hFFFF003C, 32'd4, 4'hF);
    check("t2_clr", 32'(timer_int[1]), 32'd0);

    // PWM 3 high / 7 low
    bus_wr(32'hFFFF0040, 32'd10, 4'hF);
    bus_wr(32'hFFFF0044, 32'd3, 4'hF);
    bus_wr(32'hFFFF0048, 32'd1, 4'hF);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      d[0] = pwm_out;
      @(posedge clk); #1;
      if (!d[0] && pwm_out) found = 1'b1;
    end
    check("pwm_rise_seen", 32'(found), 32'd1);
    bad = 0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
      if (pwm_out !== ((i % 10) < 3)) bad++;
    end
    check("pwm_3_7", 32'(bad), 32'd0);
    bus_wr(32'hFFFF0044, 32'd12, 4'hF);
    repeat (2) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (pwm_out !== 1'b1) bad++;
    end
    check("pwm_duty_ge_per", 32'(bad), 32'd0);
    bus_wr(32'hFFFF0040, 32'd0, 4'hF);
    repeat (2) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (pwm_out !== 1'b0) bad++;
    end
    check("pwm_per0", 32'(bad), 32'd0);
    bus_wr(32'hFFFF0048, 32'd0, 4'hF);

    // Keypad: column 2 pressed on row 1 -> code 6
    key_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      bus_rd(32'hFFFFFC14, d);
      if (d[0]) found = 1'b1;
    end
    key_en = 1'b0;
    check("key_valid_seen", 32'(found), 32'd1);
    bus_rd(32'hFFFFFC10, d);
    check("key_code", d, 32'd6);
    bus_rd(32'hFFFFFC14, d);
    check("key_stat", d, 32'd1);
    bus_wr(32'hFFFFFC14, 32'd1, 4'hF);
    bus_rd(32'hFFFFFC14, d);
    check("key_stat_clr", d, 32'd0);

    // UART TX pulse
    bus_wr(32'hFFFF0000, 32'h41, 4'hF);
    check("tx_en_pulse", 32'(uart_tx_en), 32'd1);
    check("tx_data", 32'(uart_tx_data), 32'h41);
    @(posedge clk); #1;
    check("tx_en_drop", 32'(uart_tx_en), 32'd0);
    bus_rd(32'hFFFF0000, d);
    check("tx_rd", d, 32'h41);

    // Watchdog: kicks every 9 cycles, then starve
    bus_wr(32'hFFFF0054, 32'd1, 4'hF);
    bad = 0;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 8; j++) begin
        @(posedge clk); #1;
        if (sys_rst_req) bad++;
      end
      bus_wr(32'hFFFF0050, 32'h0, 4'hF);
      if (sys_rst_req) bad++;
    end
    check("wdt_kicked_no_req", 32'(bad), 32'd0);
    bad = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (sys_rst_req) bad++;
    end
    check("wdt_no_early_req", 32'(bad), 32'd0);
    @(posedge clk); #1;
    check("wdt_req_21", 32'(sys_rst_req), 32'd1);
    @(posedge clk); #1;
    check("wdt_req_drop", 32'(sys_rst_req), 32'd0);
    check("wdt_led_reset", 32'(led_out), 32'h0);
    check("wdt_disp_reset", disp_data, 32'h0);
    check("wdt_tx_reset", 32'(uart_tx_data), 32'h0);
    bus_rd(32'hFFFF0054, d);
    check("wdt_ctrl_reset", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
